// File: rtl/gcd_lcm_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gcd_lcm_engine : binary-GCD engine with optional LCM (divide + shift-add)   |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module gcd_lcm_engine #(
  parameter int W   = 8,
  parameter int ICW = 16
) (
  input  logic                 board_clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Ack,
  input  logic                 Mode,
  input  logic                 Step,
  input  logic                 CEN,
  input  logic [W-1:0]         Ain,
  input  logic [W-1:0]         Bin,
  output logic [W-1:0]         A,
  output logic [W-1:0]         B,
  output logic [2*W-1:0]       Result,
  output logic [$clog2(W):0]   i_count,
  output logic [ICW-1:0]       iter_count,
  output logic                 Err,
  output logic                 q_I,
  output logic                 q_Sub,
  output logic                 q_Mult,
  output logic                 q_Div,
  output logic                 q_LMul,
  output logic                 q_Done
);

  localparam int c_CW = $clog2(W) + 1;

  localparam logic [5:0] c_ST_INI  = 6'b000001;
  localparam logic [5:0] c_ST_SUB  = 6'b000010;
  localparam logic [5:0] c_ST_MULT = 6'b000100;
  localparam logic [5:0] c_ST_DIV  = 6'b001000;
  localparam logic [5:0] c_ST_LMUL = 6'b010000;
  localparam logic [5:0] c_ST_DONE = 6'b100000;

  localparam logic [c_CW-1:0] c_CNT_ONE  = 1;
  localparam logic [c_CW-1:0] c_LMUL_LAST = c_CW'(W - 1);
  localparam logic [W-1:0]    c_Q_ONE    = 1;
  localparam logic [ICW-1:0]  c_ITER_ONE = 1;

  logic [5:0]       r_state;
  logic [5:0]       w_next_state;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_aorig;
  logic [W-1:0]     r_borig;
  logic             r_mode;
  logic [2*W-1:0]   r_result;
  logic [c_CW-1:0]  r_i_count;
  logic [ICW-1:0]   r_iter;
  logic             r_err;
  logic [W-1:0]     r_r;
  logic [W-1:0]     r_q;
  logic [2*W-1:0]   r_mcand;
  logic [c_CW-1:0]  r_lcnt;

  logic             w_adv;
  logic             w_zero_op;
  logic             w_r_ge;
  logic [ICW-1:0]   w_iter_inc;

  assign w_adv      = Step ? CEN : 1'b1;
  assign w_zero_op  = (Ain == '0) || (Bin == '0);
  assign w_r_ge     = ({{W{1'b0}}, r_r} >= r_result);
  assign w_iter_inc = (&r_iter) ? r_iter : (r_iter + c_ITER_ONE);

  // State register
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      r_state <= c_ST_INI;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; Start and Ack bypass the advance qualifier
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_INI: begin
        if (Start) begin
          w_next_state = w_zero_op ? c_ST_DONE : c_ST_SUB;
        end
      end
      c_ST_SUB: begin
        if (w_adv && (r_a == r_b)) begin
          w_next_state = c_ST_MULT;
        end
      end
      c_ST_MULT: begin
        if (w_adv && (r_i_count == '0)) begin
          w_next_state = r_mode ? c_ST_DIV : c_ST_DONE;
        end
      end
      c_ST_DIV: begin
        if (w_adv && !w_r_ge) begin
          w_next_state = c_ST_LMUL;
        end
      end
      c_ST_LMUL: begin
        if (w_adv && (r_lcnt == c_LMUL_LAST)) begin
          w_next_state = c_ST_DONE;
        end
      end
      c_ST_DONE: begin
        if (Ack) begin
          w_next_state = c_ST_INI;
        end
      end
      default: begin
        w_next_state = c_ST_INI;
      end
    endcase
  end

  // State decode
  always_comb begin
    q_I    = r_state[0];
    q_Sub  = r_state[1];
    q_Mult = r_state[2];
    q_Div  = r_state[3];
    q_LMul = r_state[4];
    q_Done = r_state[5];
  end

  // Datapath
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_aorig   <= '0;
      r_borig   <= '0;
      r_mode    <= 1'b0;
      r_result  <= '0;
      r_i_count <= '0;
      r_iter    <= '0;
      r_err     <= 1'b0;
      r_r       <= '0;
      r_q       <= '0;
      r_mcand   <= '0;
      r_lcnt    <= '0;
    end else begin
      case (r_state)
        c_ST_INI: begin
          if (Start) begin
            r_a       <= Ain;
            r_b       <= Bin;
            r_aorig   <= Ain;
            r_borig   <= Bin;
            r_mode    <= Mode;
            r_i_count <= '0;
            r_iter    <= '0;
            r_result  <= '0;
            r_err     <= w_zero_op;
          end
        end
        c_ST_SUB: begin
          if (w_adv) begin
            r_iter <= w_iter_inc;
            if (r_a == r_b) begin
              r_result <= {{W{1'b0}}, r_a};
            end else if (!r_a[0] && !r_b[0]) begin
              r_a       <= r_a >> 1;
              r_b       <= r_b >> 1;
              r_i_count <= r_i_count + c_CNT_ONE;
            end else if (!r_a[0]) begin
              r_a <= r_a >> 1;
            end else if (!r_b[0]) begin
              r_b <= r_b >> 1;
            end else if (r_a > r_b) begin
              r_a <= r_a - r_b;
            end else begin
              r_b <= r_b - r_a;
            end
          end
        end
        c_ST_MULT: begin
          if (w_adv) begin
            r_iter <= w_iter_inc;
            if (r_i_count != '0) begin
              r_result  <= r_result << 1;
              r_i_count <= r_i_count - c_CNT_ONE;
            end else begin
              r_r <= r_aorig;
              r_q <= '0;
            end
          end
        end
        c_ST_DIV: begin
          if (w_adv) begin
            r_iter <= w_iter_inc;
            // The GCD always fits in W bits, so only the low half takes part
            if (w_r_ge) begin
              r_r <= r_r - r_result[W-1:0];
              r_q <= r_q + c_Q_ONE;
            end else begin
              r_result <= '0;
              r_mcand  <= {{W{1'b0}}, r_borig};
              r_lcnt   <= '0;
            end
          end
        end
        c_ST_LMUL: begin
          if (w_adv) begin
            r_iter <= w_iter_inc;
            if (r_q[0]) begin
              r_result <= r_result + r_mcand;
            end
            r_q     <= r_q >> 1;
            r_mcand <= r_mcand << 1;
            r_lcnt  <= r_lcnt + c_CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign A          = r_a;
  assign B          = r_b;
  assign Result     = r_result;
  assign i_count    = r_i_count;
  assign iter_count = r_iter;
  assign Err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gcd_lcm_engine.sv
`default_nettype none
// Directed self-checking bench for gcd_lcm_engine (W=8 and W=16 instances).
module tb_gcd_lcm_engine;

  logic        board_clk = 1'b0;
  logic        Reset, Start, Ack, Mode, Step, CEN;
  logic [7:0]  Ain, Bin, A, B;
  logic [15:0] Result;
  logic [3:0]  i_count;
  logic [15:0] iter_count;
  logic        Err, q_I, q_Sub, q_Mult, q_Div, q_LMul, q_Done;
  logic [5:0]  qv;

  logic        rst16, start16;
  logic [15:0] ain16, bin16, a16, b16;
  logic [31:0] result16;
  logic [4:0]  icnt16;
  logic [15:0] iter16;
  logic        err16, qi16, qs16, qm16, qd16, ql16, qdone16;
  logic        done16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 board_clk = ~board_clk;

  assign qv = {q_Done, q_LMul, q_Div, q_Mult, q_Sub, q_I};

  gcd_lcm_engine #(.W(8), .ICW(16)) dut (
    .board_clk(board_clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .Mode(Mode), .Step(Step), .CEN(CEN), .Ain(Ain), .Bin(Bin),
    .A(A), .B(B), .Result(Result), .i_count(i_count), .iter_count(iter_count),
    .Err(Err), .q_I(q_I), .q_Sub(q_Sub), .q_Mult(q_Mult), .q_Div(q_Div),
    .q_LMul(q_LMul), .q_Done(q_Done)
  );

  gcd_lcm_engine #(.W(16), .ICW(16)) dut16 (
    .board_clk(board_clk), .Reset(rst16), .Start(start16), .Ack(1'b0),
    .Mode(1'b1), .Step(1'b0), .CEN(1'b0), .Ain(ain16), .Bin(bin16),
    .A(a16), .B(b16), .Result(result16), .i_count(icnt16), .iter_count(iter16),
    .Err(err16), .q_I(qi16), .q_Sub(qs16), .q_Mult(qm16), .q_Div(qd16),
    .q_LMul(ql16), .q_Done(qdone16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic m, input logic [7:0] a, input logic [7:0] b);
    Mode = m; Ain = a; Bin = b; Start = 1'b1;
    @(negedge board_clk);
    Start = 1'b0;
  endtask

  task automatic ack_op();
    Ack = 1'b1;
    @(negedge board_clk);
    Ack = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!q_Done && k < budget) begin
      @(negedge board_clk);
      k++;
    end
    check(tag, q_Done, 1);
  endtask

  // 16-bit LCM runs concurrently with the 8-bit directed sequence
  initial begin
    done16 = 1'b0; rst16 = 1'b1; start16 = 1'b0; ain16 = '0; bin16 = '0;
    repeat (2) @(negedge board_clk);
    rst16 = 1'b0;
    ain16 = 16'd65535; bin16 = 16'd65534; start16 = 1'b1;
    @(negedge board_clk);
    start16 = 1'b0;
    for (int k = 0; k < 80000 && !qdone16; k++) @(negedge board_clk);
    check("w16_done", qdone16, 1);
    check("w16_lcm", result16, 64'd4294770690);
    check("w16_err", err16, 0);
    done16 = 1'b1;
  end

  initial begin
    logic [7:0] exp_a [5];
    logic [7:0] exp_b [5];
    exp_a = '{18, 9, 9, 6, 3};
    exp_b = '{12, 6, 3, 3, 3};

    Reset = 1'b1; Start = 1'b0; Ack = 1'b0; Mode = 1'b0; Step = 1'b0; CEN = 1'b0;
    Ain = '0; Bin = '0;
    repeat (3) @(negedge board_clk);
    check("rst_state", qv, 6'b000001);
    check("rst_result", Result, 0);
    check("rst_a", A, 0);
    check("rst_iter", iter_count, 0);
    check("rst_err", Err, 0);
    Reset = 1'b0;

    // GCD(36,24) with the SUB trace
    start_op(1'b0, 8'd36, 8'd24);
    check("gcd_load_state", qv, 6'b000010);
    check("gcd_load_ab", {A, B}, {8'd36, 8'd24});
    for (int i = 0; i < 5; i++) begin
      @(negedge board_clk);
      check($sformatf("gcd_sub%0d", i), {A, B}, {exp_a[i], exp_b[i]});
    end
    wait_done("gcd_done", 100);
    check("gcd_result", Result, 12);
    check("gcd_icount", i_count, 0);
    check("gcd_iter", iter_count, 9);
    check("gcd_err", Err, 0);
    repeat (4) @(negedge board_clk);
    check("gcd_hold_done", qv, 6'b100000);
    // Start and Ack together in DONE: Ack wins, nothing reloads
    Start = 1'b1; Ack = 1'b1; Ain = 8'd50; Bin = 8'd10;
    @(negedge board_clk);
    Start = 1'b0; Ack = 1'b0;
    check("startack_state", qv, 6'b000001);
    check("startack_a", A, 3);
    repeat (3) @(negedge board_clk);
    check("ini_hold_result", Result, 12);
    check("ini_hold_iter", iter_count, 9);

    // LCM(36,24) with inputs disturbed mid-run
    start_op(1'b1, 8'd36, 8'd24);
    Mode = 1'b0; Ain = 8'd99; Bin = 8'd7;
    Start = 1'b1; @(negedge board_clk); Start = 1'b0;
    Ack = 1'b1; @(negedge board_clk); Ack = 1'b0;
    wait_done("lcm_done", 100);
    check("lcm_result", Result, 72);
    check("lcm_iter", iter_count, 21);
    check("lcm_err", Err, 0);
    ack_op();
    check("lcm_ack_state", qv, 6'b000001);

    // Zero operand
    start_op(1'b0, 8'd0, 8'd17);
    check("zero_state", qv, 6'b100000);
    check("zero_err", Err, 1);
    check("zero_result", Result, 0);
    check("zero_iter", iter_count, 0);
    ack_op();

    // Single-step
    Step = 1'b1; CEN = 1'b0;
    start_op(1'b0, 8'd36, 8'd24);
    repeat (50) @(negedge board_clk);
    check("step_hold_state", qv, 6'b000010);
    check("step_hold_ab", {A, B}, {8'd36, 8'd24});
    for (int i = 0; i < 3; i++) begin
      CEN = 1'b1; @(negedge board_clk);
      CEN = 1'b0; @(negedge board_clk);
    end
    check("step_ab", {A, B}, {8'd9, 8'd3});
    check("step_icount", i_count, 2);
    Step = 1'b0;
    wait_done("step_done", 100);
    check("step_result", Result, 12);
    ack_op();

    // Reset mid-DIV, then an immediate restart
    start_op(1'b1, 8'd255, 8'd254);
    for (int k = 0; k < 2000 && !q_Div; k++) @(negedge board_clk);
    check("abort_reach_div", q_Div, 1);
    repeat (5) @(negedge board_clk);
    #2 Reset = 1'b1;
    #1;
    check("abort_state", qv, 6'b000001);
    check("abort_outs", {A, B, Result, i_count, iter_count, Err}, 0);
    @(negedge board_clk);
    Reset = 1'b0;
    start_op(1'b1, 8'd6, 8'd4);
    check("restart_ab", {A, B}, {8'd6, 8'd4});
    wait_done("restart_done", 200);
    check("restart_result", Result, 12);
    ack_op();

    for (int k = 0; k < 90000 && !done16; k++) @(negedge board_clk);
    check("w16_finished", done16, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gcd_lcm_engine.md
GCD_LCM_ENGINE -- requirements
Module: gcd_lcm_engine

Interface
REQ-001 Parameter W, default 8: operand width, legal range 4..32.
REQ-002 Parameter ICW, default 16: iteration-counter width.
REQ-003 board_clk  in  1  clock; all state changes on the rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 Start  in  1  single-cycle pulse; begins a computation.
REQ-006 Ack  in  1  single-cycle pulse; releases DONE.
REQ-007 Mode  in  1  0 = GCD, 1 = LCM; sampled only on an accepted Start.
REQ-008 Step  in  1  1 = single-step mode; 0 = free-run.
REQ-009 CEN  in  1  step pulse; used only when Step=1.
REQ-010 Ain, Bin  in  W each  operands; sampled only on an accepted Start.
REQ-011 A, B  out  W each  working registers.
REQ-012 Result  out  2W  GCD (zero-extended) or LCM.
REQ-013 i_count  out  $clog2(W)+1  common factor-of-two count.
REQ-014 iter_count  out  ICW  count of executed compute cycles.
REQ-015 Err  out  1  zero-operand flag.
REQ-016 q_I, q_Sub, q_Mult, q_Div, q_LMul, q_Done  out  1 each  one-hot state.

Function
REQ-017 States SHALL be INI, SUB, MULT, DIV, LMUL and DONE, one-hot encoded, with exactly one q_* high at all times.
REQ-018 An advance cycle SHALL be every clock when Step=0, and a clock with CEN=1 when Step=1; SUB, MULT, DIV and LMUL SHALL change state or registers only on advance cycles.
REQ-019 INI: Start=1 (independent of Step/CEN) SHALL load A<=Ain, B<=Bin, internal Aorig<=Ain, Borig<=Bin, latch Mode, clear i_count, iter_count, Result and Err, and go to SUB.
REQ-020 INI with Start=1 and Ain==0 or Bin==0 SHALL go directly to DONE with Err=1 and Result=0.
REQ-021 SUB, per advance cycle, first matching rule applies:
- A==B: Result<=zero-extended A, go to MULT.
- A and B both even: shift both right 1, i_count+1.
- A even: A>>1.
- B even: B>>1.
- A>B: A<=A-B; otherwise B<=B-A.
REQ-022 MULT, per advance cycle:
- i_count!=0: Result<=Result<<1, i_count-1.
- i_count==0: go to DONE if Mode=0, else DIV.
REQ-023 DIV: using internal R (loaded with Aorig on MULT exit) and quotient Q (cleared on MULT exit), per advance cycle:
- R>=Result: R<=R-Result, Q+1.
- Otherwise go to LMUL.
REQ-024 LMUL: exactly W advance cycles of shift-add, computing Q*Borig into Result (2W bits, no truncation), then go to DONE.
REQ-025 iter_count SHALL increment on every advance cycle spent in SUB, MULT, DIV or LMUL, and saturate at all-ones.
REQ-026 DONE: Ack=1 (independent of Step/CEN) SHALL go to INI.
REQ-027 Result, Err, A, B, i_count and iter_count SHALL hold their values in DONE and in INI until the next accepted Start.
REQ-028 Start outside INI and Ack outside DONE SHALL be ignored.
REQ-029 Start and Ack asserted in the same cycle SHALL act per the current state only.
REQ-030 Changing Mode, Ain or Bin mid-computation SHALL have no effect.
REQ-031 Changing Step mid-computation SHALL take effect on the next clock.

Reset
REQ-032 Reset=1 SHALL asynchronously force state INI and clear A, B, Result, i_count, iter_count, Err, Q, R, Aorig, Borig and the latched mode to 0.
REQ-033 Reset asserted in any state, including mid-SUB/DIV/LMUL, SHALL abort the computation, and no partial Result SHALL survive.
REQ-034 After Reset deassertion, the first Start SHALL be accepted on the next rising edge.

Verification
REQ-035 W=8, Mode=0, Step=0, Ain=36, Bin=24, Start -> SUB sequence (18,12), (9,6), (9,3), (6,3), (3,3), then exit; Result=12, i_count=0 in DONE, iter_count=9, Err=0.
REQ-036 Same operands, Mode=1 -> Result=72, iter_count=21 (9 + 4 DIV + 8 LMUL), q_Done=1 until Ack, then q_I=1.
REQ-037 Ain=0, Bin=17, Start -> DONE on the next edge, Err=1, Result=0, iter_count=0.
REQ-038 Step=1, Ain=36, Bin=24, CEN held low for 50 cycles after Start -> q_Sub=1 and A=36, B=24 unchanged; three CEN pulses -> A=9, B=3, i_count=2.
REQ-039 Mode=1, Ain=255, Bin=254, Reset pulsed mid-DIV -> all outputs 0 and q_I=1 immediately; Start with 6, 4 then yields Result=12.
REQ-040 W=16, Mode=1, Ain=65535, Bin=65534 -> Result=4294770690 (no truncation), Err=0.
